// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM update sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_W = 16;

    // Write-select encoding on the PWM register-write bus
    localparam logic [1:0] SEL_IDLE = 2'd0;
    localparam logic [1:0] SEL_CMP  = 2'd1;
    localparam logic [1:0] SEL_TOP  = 2'd2;
    localparam logic [1:0] SEL_CNT  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WR_TOP,
        WR_CMP,
        WR_CNT
    } pwm_state_t;

    // Default-width request entry; pwm_loader builds the same layout sized by W
    typedef struct packed {
        logic [PWM_W-1:0] top;
        logic [PWM_W-1:0] cmp;
        logic             restart;
        logic             sync;
    } pwm_req_t;

endpackage

// File: rtl/pwm_req_fifo.sv
// Generic request FIFO: DEPTH entries of type T, power-of-two DEPTH >= 2.
// Latency: an entry pushed at one edge is visible at the head from the next cycle.
// Backpressure: full blocks push; simultaneous push/pop keeps level unchanged.
module pwm_req_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  T                             push_dat,
    input  logic                         pop,
    output T                             pop_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage array; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; level never exceeds DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pwm_loader.sv
// Replays buffered (top, cmp, restart) requests onto the PWM d/sel write bus.
// Latency: push at edge N into idle/empty -> pop at N+1 -> top write in cycle N+2 (sync=0).
// Backpressure: req_ready = FIFO not full; a sync request stalls in WAIT until pwm_cnt==0.
module pwm_loader
    import pwm_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [W-1:0]                 req_top,
    input  logic [W-1:0]                 req_cmp,
    input  logic                         req_restart,
    input  logic                         req_sync,
    input  logic [W-1:0]                 pwm_cnt,
    output logic [W-1:0]                 d,
    output logic [1:0]                   sel,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    // Same field order as pwm_req_t, sized by W
    typedef struct packed {
        logic [W-1:0] top;
        logic [W-1:0] cmp;
        logic         restart;
        logic         sync;
    } req_t;

    req_t       push_dat;
    req_t       head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    pwm_state_t state;
    pwm_state_t state_n;
    logic [W-1:0] wk_top;
    logic [W-1:0] wk_cmp;
    logic         wk_restart;

    assign push_dat  = '{top: req_top, cmp: req_cmp, restart: req_restart, sync: req_sync};
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = !empty || (state != IDLE);

    pwm_req_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // State register and working copy of the request being replayed
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wk_top     <= '0;
            wk_cmp     <= '0;
            wk_restart <= 1'b0;
        end else begin
            state <= state_n;
            if (pop) begin
                wk_top     <= head.top;
                wk_cmp     <= head.cmp;
                wk_restart <= head.restart;
            end
        end
    end

    // Next-state and write-bus decode; d/sel come only from state and working regs
    always_comb begin
        state_n = state;
        sel     = SEL_IDLE;
        d       = '0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_n = head.sync ? WAIT : WR_TOP;
                end
            end
            WAIT: begin
                if (pwm_cnt == '0) begin
                    state_n = WR_TOP;
                end
            end
            WR_TOP: begin
                sel     = SEL_TOP;
                d       = wk_top;
                state_n = WR_CMP;
            end
            WR_CMP: begin
                sel     = SEL_CMP;
                d       = wk_cmp;
                state_n = wk_restart ? WR_CNT : IDLE;
            end
            WR_CNT: begin
                sel     = SEL_CNT;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
